// File: rtl/hyperbus_target.sv
// HyperBus follower at word level: decodes the command/address, counts initial
// latency, and serves read/write bursts to a synchronous memory port plus ID0/CR0.
module hyperbus_target #(
    parameter int              WIDTH         = 8,
    parameter int              TACC_COUNT    = 5,
    parameter bit              FIXED_LATENCY = 1'b1,
    parameter int              WRAP_WORDS    = 16,
    parameter int              ADDR_LENGTH   = 32,
    parameter logic [15:0]     ID0_VALUE     = 16'h0c81,
    parameter logic [15:0]     CR0_RESET     = 16'h8f1f
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hbus_rstn,
    input  logic                   hbus_csn,
    input  logic [2*WIDTH-1:0]     dq_i,
    output logic [2*WIDTH-1:0]     dq_o,
    output logic                   dq_oe,
    input  logic [1:0]             rwds_i,
    output logic [1:0]             rwds_o,
    output logic                   rwds_oe,
    output logic [ADDR_LENGTH-1:0] mem_adr,
    output logic                   mem_re,
    input  logic [2*WIDTH-1:0]     mem_rdat,
    output logic                   mem_we,
    output logic [2*WIDTH-1:0]     mem_wdat,
    output logic [1:0]             mem_be,
    output logic [15:0]            cr0,
    output logic [2:0]             o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CA      = 3'd1,
        S_LATENCY = 3'd2,
        S_READ    = 3'd3,
        S_WRITE   = 3'd4,
        S_REGWR   = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [7:0] LAT_INIT =
        8'((FIXED_LATENCY ? 2 * TACC_COUNT : TACC_COUNT) - 1);
    localparam logic [ADDR_LENGTH-1:0] CR0_ADR   = ADDR_LENGTH'(32'h800);
    localparam logic [ADDR_LENGTH-1:0] WRAP_MASK = ADDR_LENGTH'(WRAP_WORDS - 1);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [31:0]              r_ca_hi;
    logic                     r_ca_cnt;
    logic                     r_rw;
    logic                     r_as;
    logic                     r_lin;
    logic [ADDR_LENGTH-1:0]   r_adr;
    logic [7:0]               r_lat;
    logic [2*WIDTH-1:0]       r_dq_o;
    logic [15:0]              r_cr0;

    logic                     w_active;
    logic [31:0]              w_ca_adr;
    logic [ADDR_LENGTH-1:0]   w_adr_inc;
    logic [ADDR_LENGTH-1:0]   w_adr_next;
    logic [15:0]              w_reg_rdata;
    logic                     w_rd_load;
    logic                     w_rd_adv;
    logic                     w_wr;

    // r_ca_hi holds ca[47:16]; the last CA word is decoded straight from dq_i.
    assign w_active  = hbus_rstn & ~hbus_csn;
    assign w_ca_adr  = {r_ca_hi[28:0], dq_i[2:0]};
    assign w_adr_inc = r_adr + 1'b1;
    assign w_adr_next = r_lin ? w_adr_inc
                              : ((r_adr & ~WRAP_MASK) | (w_adr_inc & WRAP_MASK));

    // Read pipeline: memory prefetch starts one cycle before the register load.
    assign w_rd_load = (r_state == S_READ) || (r_state == S_LATENCY && r_lat == 8'd0 && r_rw);
    assign w_rd_adv  = w_active && r_rw &&
                       ((r_state == S_READ) ||
                        (r_state == S_LATENCY && (r_lat == 8'd0 || (r_lat == 8'd1 && !r_as))));
    assign w_wr      = w_active && (r_state == S_WRITE);

    always_comb begin
        w_reg_rdata = 16'h0000;
        if (r_adr == '0)
            w_reg_rdata = ID0_VALUE;
        else if (r_adr == CR0_ADR)
            w_reg_rdata = r_cr0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (!hbus_rstn || hbus_csn) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    w_next_state = S_CA;
                S_CA:      if (r_ca_cnt)
                               w_next_state = (r_ca_hi[30] && !r_ca_hi[31]) ? S_REGWR : S_LATENCY;
                S_LATENCY: if (r_lat == 8'd0)
                               w_next_state = r_rw ? S_READ : S_WRITE;
                S_READ:    w_next_state = S_READ;
                S_WRITE:   w_next_state = S_WRITE;
                S_REGWR:   w_next_state = S_DONE;
                S_DONE:    w_next_state = S_DONE;
                default:   w_next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        dq_oe       = 1'b0;
        dq_o        = '0;
        rwds_oe     = 1'b0;
        rwds_o      = 2'b00;
        mem_re      = w_rd_adv && !r_as;
        mem_we      = w_wr;
        mem_adr     = r_adr;
        mem_wdat    = '0;
        mem_be      = 2'b00;
        cr0         = r_cr0;
        o_dbg_state = r_state;
        case (r_state)
            S_CA: begin
                rwds_oe = 1'b1;
                rwds_o  = FIXED_LATENCY ? 2'b11 : 2'b00;
            end
            S_READ: begin
                dq_oe   = 1'b1;
                dq_o    = r_dq_o;
                rwds_oe = 1'b1;
                rwds_o  = 2'b10;
            end
            default: ;
        endcase
        // RWDS high on a write masks that byte.
        if (w_wr) begin
            mem_wdat = dq_i;
            mem_be   = ~rwds_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ca_hi  <= '0;
            r_ca_cnt <= 1'b0;
            r_rw     <= 1'b0;
            r_as     <= 1'b0;
            r_lin    <= 1'b0;
            r_adr    <= '0;
            r_lat    <= '0;
            r_dq_o   <= '0;
            r_cr0    <= CR0_RESET;
        end else if (!hbus_rstn) begin
            r_ca_hi  <= '0;
            r_ca_cnt <= 1'b0;
            r_rw     <= 1'b0;
            r_as     <= 1'b0;
            r_lin    <= 1'b0;
            r_adr    <= '0;
            r_lat    <= '0;
            r_dq_o   <= '0;
            r_cr0    <= CR0_RESET;
        end else begin
            if (r_state == S_IDLE && !hbus_csn) begin
                r_ca_hi[31:16] <= dq_i[15:0];
                r_ca_cnt       <= 1'b0;
            end
            if (r_state == S_CA) begin
                r_ca_cnt <= 1'b1;
                if (!r_ca_cnt) begin
                    r_ca_hi[15:0] <= dq_i[15:0];
                end else begin
                    r_rw  <= r_ca_hi[31];
                    r_as  <= r_ca_hi[30];
                    r_lin <= r_ca_hi[29];
                    r_adr <= ADDR_LENGTH'(w_ca_adr);
                    r_lat <= LAT_INIT;
                end
            end
            if (r_state == S_LATENCY && r_lat != 8'd0)
                r_lat <= r_lat - 8'd1;
            if (r_state == S_REGWR && w_active && r_adr == CR0_ADR)
                r_cr0 <= dq_i[15:0];
            if (w_rd_load && w_active)
                r_dq_o <= r_as ? (2*WIDTH)'(w_reg_rdata) : mem_rdat;
            if (w_rd_adv || w_wr)
                r_adr <= w_adr_next;
        end
    end

endmodule

// File: tb/tb_hyperbus_target.sv
// Directed bench for hyperbus_target: writes, masked writes, linear/wrapped
// reads, register space, bus reset, abort and asynchronous reset.
module tb_hyperbus_target;

    logic        clk = 1'b0;
    logic        rst;
    logic        hbus_rstn;
    logic        hbus_csn;
    logic [15:0] dq_i;
    logic [15:0] dq_o;
    logic        dq_oe;
    logic [1:0]  rwds_i;
    logic [1:0]  rwds_o;
    logic        rwds_oe;
    logic [31:0] mem_adr;
    logic        mem_re;
    logic [15:0] mem_rdat = 16'h0000;
    logic        mem_we;
    logic [15:0] mem_wdat;
    logic [1:0]  mem_be;
    logic [15:0] cr0;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    int we_cnt;

    hyperbus_target dut (
        .clk         (clk),
        .rst         (rst),
        .hbus_rstn   (hbus_rstn),
        .hbus_csn    (hbus_csn),
        .dq_i        (dq_i),
        .dq_o        (dq_o),
        .dq_oe       (dq_oe),
        .rwds_i      (rwds_i),
        .rwds_o      (rwds_o),
        .rwds_oe     (rwds_oe),
        .mem_adr     (mem_adr),
        .mem_re      (mem_re),
        .mem_rdat    (mem_rdat),
        .mem_we      (mem_we),
        .mem_wdat    (mem_wdat),
        .mem_be      (mem_be),
        .cr0         (cr0),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Memory returns address + 0x100 one cycle after a read strobe.
    always @(posedge clk) begin
        if (mem_re)
            mem_rdat <= mem_adr[15:0] + 16'h0100;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic csn, input logic [15:0] dq, input logic [1:0] rw);
        @(negedge clk);
        hbus_csn = csn;
        dq_i     = dq;
        rwds_i   = rw;
        #1;
    endtask

    task automatic ca(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
        step(1'b0, w0, 2'b00);
        step(1'b0, w1, 2'b00);
        chk("ca_rwds_oe", rwds_oe, 1);
        chk("ca_rwds_o", rwds_o, 2'b11);
        step(1'b0, w2, 2'b00);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 16'h0000, 2'b00);
    endtask

    initial begin
        rst = 1'b1; hbus_rstn = 1'b1; hbus_csn = 1'b1; dq_i = '0; rwds_i = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", dbg_state, 0);
        chk("rst_dq_oe", dq_oe, 0);
        chk("rst_rwds_oe", rwds_oe, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_dq_o", dq_o, 0);
        chk("rst_rwds_o", rwds_o, 0);
        chk("rst_mem_adr", mem_adr, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_cr0", cr0, 16'h8f1f);
        rst = 1'b0;
        idle(2);

        // Linear write at 0x10, then a masked word.
        ca(16'h2000, 16'h0002, 16'h0000);
        step(1'b0, 16'h0000, 2'b00);
        chk("wr_lat_state", dbg_state, 2);
        chk("wr_lat_rwds_oe", rwds_oe, 0);
        repeat (9) step(1'b0, 16'h0000, 2'b00);
        chk("wr_lat_last_we", mem_we, 0);
        step(1'b0, 16'haaaa, 2'b00);
        chk("wr0_we", mem_we, 1);
        chk("wr0_adr", mem_adr, 32'h10);
        chk("wr0_wdat", mem_wdat, 16'haaaa);
        chk("wr0_be", mem_be, 2'b11);
        chk("wr0_dq_oe", dq_oe, 0);
        step(1'b0, 16'h5555, 2'b00);
        chk("wr1_adr", mem_adr, 32'h11);
        chk("wr1_wdat", mem_wdat, 16'h5555);
        chk("wr1_be", mem_be, 2'b11);
        step(1'b0, 16'h1234, 2'b10);
        chk("wr2_adr", mem_adr, 32'h12);
        chk("wr2_wdat", mem_wdat, 16'h1234);
        chk("wr2_be", mem_be, 2'b01);
        step(1'b1, 16'h0000, 2'b00);
        chk("wr_end_we", mem_we, 0);
        idle(1);
        chk("wr_end_state", dbg_state, 0);

        // Linear read at 0x20.
        ca(16'ha000, 16'h0004, 16'h0000);
        repeat (8) step(1'b0, 16'h0000, 2'b00);
        step(1'b0, 16'h0000, 2'b00);
        chk("rd_prefetch_re", mem_re, 1);
        chk("rd_prefetch_adr", mem_adr, 32'h20);
        step(1'b0, 16'h0000, 2'b00);
        step(1'b0, 16'h0000, 2'b00);
        chk("rd0_dq", dq_o, 16'h0120);
        chk("rd0_dq_oe", dq_oe, 1);
        chk("rd0_rwds_o", rwds_o, 2'b10);
        chk("rd0_rwds_oe", rwds_oe, 1);
        step(1'b0, 16'h0000, 2'b00);
        chk("rd1_dq", dq_o, 16'h0121);
        step(1'b0, 16'h0000, 2'b00);
        chk("rd2_dq", dq_o, 16'h0122);
        step(1'b1, 16'h0000, 2'b00);
        chk("rd_csn_same_oe", dq_oe, 1);
        step(1'b1, 16'h0000, 2'b00);
        chk("rd_csn_next_oe", dq_oe, 0);
        chk("rd_csn_next_rwds_oe", rwds_oe, 0);
        chk("rd_csn_next_re", mem_re, 0);
        idle(1);

        // Wrapped read starting at 0x0e.
        ca(16'h8000, 16'h0001, 16'h0006);
        repeat (8) step(1'b0, 16'h0000, 2'b00);
        step(1'b0, 16'h0000, 2'b00);
        chk("wrap_adr0", mem_adr, 32'h0e);
        step(1'b0, 16'h0000, 2'b00);
        chk("wrap_adr1", mem_adr, 32'h0f);
        step(1'b0, 16'h0000, 2'b00);
        chk("wrap_adr2", mem_adr, 32'h00);
        chk("wrap_dq0", dq_o, 16'h010e);
        step(1'b0, 16'h0000, 2'b00);
        chk("wrap_adr3", mem_adr, 32'h01);
        chk("wrap_dq1", dq_o, 16'h010f);
        step(1'b0, 16'h0000, 2'b00);
        chk("wrap_dq2", dq_o, 16'h0100);
        step(1'b0, 16'h0000, 2'b00);
        chk("wrap_dq3", dq_o, 16'h0101);
        idle(2);

        // Register read of ID0.
        ca(16'hc000, 16'h0000, 16'h0000);
        repeat (10) step(1'b0, 16'h0000, 2'b00);
        step(1'b0, 16'h0000, 2'b00);
        chk("id0_dq", dq_o, 16'h0c81);
        chk("id0_re", mem_re, 0);
        step(1'b0, 16'h0000, 2'b00);
        chk("reg1_dq", dq_o, 16'h0000);
        idle(2);

        // Zero-latency CR0 write.
        ca(16'h6000, 16'h0100, 16'h0000);
        step(1'b0, 16'h8fe6, 2'b00);
        chk("regwr_state", dbg_state, 5);
        chk("regwr_we", mem_we, 0);
        step(1'b0, 16'h0000, 2'b00);
        chk("regwr_cr0", cr0, 16'h8fe6);
        chk("regwr_done", dbg_state, 6);
        idle(2);

        // Register read of CR0.
        ca(16'he000, 16'h0100, 16'h0000);
        repeat (10) step(1'b0, 16'h0000, 2'b00);
        step(1'b0, 16'h0000, 2'b00);
        chk("cr0_rd_dq", dq_o, 16'h8fe6);
        idle(2);

        // Bus reset restores CR0.
        hbus_rstn = 1'b0;
        idle(2);
        chk("rstn_cr0", cr0, 16'h8f1f);
        chk("rstn_state", dbg_state, 0);
        hbus_rstn = 1'b1;
        idle(1);

        // Abort a write during latency.
        ca(16'h2000, 16'h0002, 16'h0000);
        step(1'b0, 16'h0000, 2'b00);
        we_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 16'hffff, 2'b00);
            if (mem_we) we_cnt++;
        end
        chk("abort_we_cnt", we_cnt, 0);
        chk("abort_state", dbg_state, 0);

        // Asynchronous reset mid-read.
        ca(16'ha000, 16'h0004, 16'h0000);
        repeat (11) step(1'b0, 16'h0000, 2'b00);
        chk("arst_pre_oe", dq_oe, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_dq_oe", dq_oe, 0);
        chk("arst_rwds_oe", rwds_oe, 0);
        chk("arst_mem_re", mem_re, 0);
        chk("arst_mem_we", mem_we, 0);
        chk("arst_state", dbg_state, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
